// File: rtl/mdu_pkg.sv
// Shared constants for the multiply/divide unit: op codes, FSM encoding and
// the fixed low-word result of a divide by zero.
package mdu_pkg;

  localparam logic [2:0] MDU_MULT  = 3'd0;
  localparam logic [2:0] MDU_MULTU = 3'd1;
  localparam logic [2:0] MDU_DIV   = 3'd2;
  localparam logic [2:0] MDU_DIVU  = 3'd3;
  localparam logic [2:0] MDU_MFHI  = 3'd4;
  localparam logic [2:0] MDU_MFLO  = 3'd5;
  localparam logic [2:0] MDU_MTHI  = 3'd6;
  localparam logic [2:0] MDU_MTLO  = 3'd7;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_CALC = 2'b01;
  localparam logic [1:0] ST_FIX  = 2'b10;

  localparam logic [31:0] MDU_DZ_LO = 32'hFFFF_FFFF;

endpackage

// File: rtl/mdu_step.sv
// One radix-2 iteration of the shared datapath: shift-add for multiply,
// restoring subtract-and-shift for divide, sharing a single adder.
module mdu_step #(
  parameter int NB_DATA = 32
) (
  input  logic                   is_div_i,
  input  logic [2*NB_DATA-1:0]   acc_i,
  input  logic [NB_DATA-1:0]     opnd_i,
  output logic [2*NB_DATA-1:0]   acc_o
);

  logic [NB_DATA+1:0] lhs;
  logic [NB_DATA+1:0] rhs;
  logic [NB_DATA+1:0] sum;

  // Divide: lhs is the remainder shifted left with the next dividend bit; the
  // extra top bit makes the sign of (lhs - divisor) unambiguous.
  always_comb begin
    if (is_div_i) begin
      lhs = {1'b0, acc_i[2*NB_DATA-1:NB_DATA], acc_i[NB_DATA-1]};
      rhs = ~{2'b00, opnd_i};
    end else begin
      lhs = {2'b00, acc_i[2*NB_DATA-1:NB_DATA]};
      rhs = acc_i[0] ? {2'b00, opnd_i} : '0;
    end
    sum = lhs + rhs + {{(NB_DATA+1){1'b0}}, is_div_i};

    if (is_div_i) begin
      if (!sum[NB_DATA+1]) begin
        acc_o = {sum[NB_DATA-1:0], acc_i[NB_DATA-2:0], 1'b1};
      end else begin
        acc_o = {lhs[NB_DATA-1:0], acc_i[NB_DATA-2:0], 1'b0};
      end
    end else begin
      acc_o = {sum[NB_DATA:0], acc_i[NB_DATA-1:1]};
    end
  end

endmodule

// File: rtl/mult_div_sequencer.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO; stalls the front of
// the pipeline while an operation runs or a HI/LO access must wait.
module mult_div_sequencer
  import mdu_pkg::*;
#(
  parameter int NB_DATA = 32,
  parameter int NB_CNT  = 6
) (
  input  logic               clk,
  input  logic               i_rst,
  input  logic               i_halt,
  input  logic               i_valid,
  input  logic [2:0]         i_op,
  input  logic [NB_DATA-1:0] i_datoA,
  input  logic [NB_DATA-1:0] i_datoB,
  output logic               o_stall,
  output logic               o_busy,
  output logic [NB_DATA-1:0] o_result,
  output logic [NB_DATA-1:0] o_hi,
  output logic [NB_DATA-1:0] o_lo
);

  localparam logic [NB_CNT-1:0] CNT_LAST = NB_CNT'(NB_DATA - 1);
  localparam logic [NB_CNT-1:0] CNT_ONE  = NB_CNT'(1);

  logic [1:0]             state_q, state_d;
  logic [NB_CNT-1:0]      cnt_q, cnt_d;
  logic [2*NB_DATA-1:0]   acc_q, acc_d;
  logic [NB_DATA-1:0]     opnd_q, opnd_d;
  logic                   is_div_q, is_div_d;
  logic                   neg_lo_q, neg_lo_d;
  logic                   neg_hi_q, neg_hi_d;
  logic                   dz_q, dz_d;
  logic [NB_DATA-1:0]     hi_q, hi_d;
  logic [NB_DATA-1:0]     lo_q, lo_d;

  logic                   is_signed;
  logic                   a_neg, b_neg;
  logic [NB_DATA-1:0]     a_mag, b_mag;
  logic [2*NB_DATA-1:0]   step_acc;
  logic [2*NB_DATA-1:0]   prod_fix;

  mdu_step #(.NB_DATA(NB_DATA)) u_step (
    .is_div_i (is_div_q),
    .acc_i    (acc_q),
    .opnd_i   (opnd_q),
    .acc_o    (step_acc)
  );

  assign is_signed = ~i_op[0];
  assign a_neg     = is_signed & i_datoA[NB_DATA-1];
  assign b_neg     = is_signed & i_datoB[NB_DATA-1];
  assign a_mag     = a_neg ? -i_datoA : i_datoA;
  assign b_mag     = b_neg ? -i_datoB : i_datoB;
  assign prod_fix  = neg_lo_q ? -acc_q : acc_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    is_div_d = is_div_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    dz_d     = dz_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    if (!i_halt) begin
      case (state_q)
        ST_IDLE: begin
          if (i_valid && !i_op[2]) begin
            is_div_d = i_op[1];
            neg_lo_d = a_neg ^ b_neg;
            neg_hi_d = a_neg;
            cnt_d    = '0;
            dz_d     = 1'b0;
            state_d  = ST_CALC;
            if (!i_op[1]) begin
              acc_d  = {{NB_DATA{1'b0}}, b_mag};
              opnd_d = a_mag;
            end else if (i_datoB == '0) begin
              // Divide by zero bypasses iteration; raw dividend goes to HI.
              acc_d   = {i_datoA, NB_DATA'(MDU_DZ_LO)};
              opnd_d  = '0;
              dz_d    = 1'b1;
              state_d = ST_FIX;
            end else begin
              acc_d  = {{NB_DATA{1'b0}}, a_mag};
              opnd_d = b_mag;
            end
          end else if (i_valid && i_op == MDU_MTHI) begin
            hi_d = i_datoA;
          end else if (i_valid && i_op == MDU_MTLO) begin
            lo_d = i_datoA;
          end
        end
        ST_CALC: begin
          acc_d = step_acc;
          if (cnt_q == CNT_LAST) begin
            state_d = ST_FIX;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        ST_FIX: begin
          state_d = ST_IDLE;
          if (!is_div_q) begin
            hi_d = prod_fix[2*NB_DATA-1:NB_DATA];
            lo_d = prod_fix[NB_DATA-1:0];
          end else if (dz_q) begin
            hi_d = acc_q[2*NB_DATA-1:NB_DATA];
            lo_d = acc_q[NB_DATA-1:0];
          end else begin
            // Quotient truncates toward zero; remainder follows the dividend.
            lo_d = neg_lo_q ? -acc_q[NB_DATA-1:0] : acc_q[NB_DATA-1:0];
            hi_d = neg_hi_q ? -acc_q[2*NB_DATA-1:NB_DATA] : acc_q[2*NB_DATA-1:NB_DATA];
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      is_div_q <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      dz_q     <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      is_div_q <= is_div_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      dz_q     <= dz_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  always_comb begin
    o_stall = 1'b0;
    if (i_valid) begin
      case (state_q)
        ST_IDLE: o_stall = ~i_op[2];
        ST_CALC: o_stall = 1'b1;
        ST_FIX:  o_stall = i_op[2];
        default: o_stall = 1'b0;
      endcase
    end
  end

  assign o_busy   = (state_q != ST_IDLE);
  assign o_result = (i_op == MDU_MFHI) ? hi_q :
                    (i_op == MDU_MFLO) ? lo_q : '0;
  assign o_hi     = hi_q;
  assign o_lo     = lo_q;

endmodule
